// File: rtl/segm_capture_if.sv
// Bundle between the multiplexed 7-segment display tap and the frame capture block.
// No latency (wires only). No backpressure: the display bus is free-running.
// value_valid and digit_err are single-cycle pulses that nothing acknowledges.
interface segm_capture_if;
    logic [6:0]  segm;
    logic [3:0]  dig_sel;
    logic [15:0] value;
    logic        value_valid;
    logic        digit_err;
    logic [1:0]  err_digit;

    modport master (
        output segm,
        output dig_sel,
        input  value,
        input  value_valid,
        input  digit_err,
        input  err_digit
    );

    modport slave (
        input  segm,
        input  dig_sel,
        output value,
        output value_valid,
        output digit_err,
        output err_digit
    );
endinterface

// File: rtl/segm_capture.sv
// Decodes a multiplexed active-low 7-segment display into a 16-bit frame.
// Latency is 2 sync + STABLE_CYCLES + 1 cycles from the input change. No backpressure: results are pulses.
// Frames are assembled one digit at a time; an undecodable digit aborts the frame in progress.
module segm_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic           clk,
    input  logic           reset,
    segm_capture_if.slave  bus
);
    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic [7:0] ACCEPT_CNT = 8'(STABLE_CYCLES - 1);

    logic [6:0]  segm_s1;
    logic [6:0]  segm_s2;
    logic [3:0]  sel_s1;
    logic [3:0]  sel_s2;
    logic [10:0] smp;
    logic [10:0] smp_q;
    logic [7:0]  stab_cnt;

    logic        accept;
    logic [6:0]  acc_segm;
    logic [3:0]  acc_sel;
    logic        sel_ok;
    logic [1:0]  sel_idx;
    logic        seg_ok;
    logic [3:0]  nib;
    logic        is_blank;
    logic        cap_vld;
    logic        err_vld;
    logic [3:0]  sel_bit;
    logic        frame_done;
    logic [15:0] frame_word;

    state_t      state_q;
    state_t      state_d;
    logic        do_capture;
    logic        do_complete;
    logic        do_abort;

    logic [3:0]  mask;
    logic [15:0] shadow;
    logic [15:0] value_q;
    logic        value_vld_q;
    logic        digit_err_q;
    logic [1:0]  err_digit_q;

    // Idle level of the bus (all ones) means blank segments and no digit selected.
    always_ff @(posedge clk) begin
        if (reset) begin
            segm_s1 <= '1;
            segm_s2 <= '1;
            sel_s1  <= '1;
            sel_s2  <= '1;
        end else begin
            segm_s1 <= bus.segm;
            segm_s2 <= segm_s1;
            sel_s1  <= bus.dig_sel;
            sel_s2  <= sel_s1;
        end
    end

    assign smp = {segm_s2, sel_s2};

    always_ff @(posedge clk) begin
        if (reset) begin
            smp_q    <= '1;
            stab_cnt <= '0;
        end else begin
            smp_q <= smp;
            if (smp == smp_q) begin
                if (stab_cnt != 8'hFF) begin
                    stab_cnt <= stab_cnt + 8'd1;
                end
            end else begin
                stab_cnt <= '0;
            end
        end
    end

    // The counter passes through ACCEPT_CNT exactly once per stable episode.
    assign accept   = (stab_cnt == ACCEPT_CNT);
    assign acc_segm = smp_q[10:4];
    assign acc_sel  = smp_q[3:0];
    assign is_blank = (acc_segm == 7'h7F);

    always_comb begin
        sel_ok  = 1'b1;
        sel_idx = 2'd0;
        case (acc_sel)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_ok  = 1'b0;
        endcase
    end

    always_comb begin
        seg_ok = 1'b1;
        nib    = 4'h0;
        case (acc_segm)
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h10: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            default: seg_ok = 1'b0;
        endcase
    end

    assign cap_vld    = accept && sel_ok && !is_blank && seg_ok;
    assign err_vld    = accept && sel_ok && !is_blank && !seg_ok;
    assign sel_bit    = 4'b0001 << sel_idx;
    assign frame_done = ((mask | sel_bit) == 4'b1111);

    always_comb begin
        frame_word = shadow;
        frame_word[{sel_idx, 2'b00} +: 4] = nib;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cap_vld) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (err_vld || (cap_vld && frame_done)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        do_capture  = 1'b0;
        do_complete = 1'b0;
        do_abort    = 1'b0;
        case (state_q)
            IDLE: begin
                do_capture = cap_vld;
                do_abort   = err_vld;
            end
            COLLECT: begin
                do_capture  = cap_vld && !frame_done;
                do_complete = cap_vld && frame_done;
                do_abort    = err_vld;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask        <= '0;
            shadow      <= '0;
            value_q     <= '0;
            value_vld_q <= 1'b0;
            digit_err_q <= 1'b0;
            err_digit_q <= '0;
        end else begin
            value_vld_q <= do_complete;
            digit_err_q <= do_abort;
            if (do_capture) begin
                shadow <= frame_word;
                mask   <= mask | sel_bit;
            end
            if (do_complete) begin
                shadow  <= frame_word;
                value_q <= frame_word;
                mask    <= '0;
            end
            // Partial nibbles stay in shadow but are dead once their mask bits clear.
            if (do_abort) begin
                mask        <= '0;
                err_digit_q <= sel_idx;
            end
        end
    end

    assign bus.value       = value_q;
    assign bus.value_valid = value_vld_q;
    assign bus.digit_err   = digit_err_q;
    assign bus.err_digit   = err_digit_q;
endmodule

// File: doc/segm_capture.md
SEGM_CAPTURE -- requirements
Module: segm_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, range 1..255: consecutive identical synchronized samples required to accept a digit.
REQ-002 clk  input  1  system clock; all logic on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 segm  input  7  external 7-segment bus, active-low, bit0=a .. bit6=g; asynchronous to clk.
REQ-005 dig_sel  input  4  external digit enables, active-low; dig_sel[i]=0 selects digit i; asynchronous.
REQ-006 value  output  16  last complete frame; nibble i = hex decoded from digit i.
REQ-007 value_valid  output  1  one-cycle pulse when value updates.
REQ-008 digit_err  output  1  one-cycle pulse on an undecodable pattern.
REQ-009 err_digit  output  2  index of the digit that caused the last digit_err; held until next error.

Function
REQ-010 segm and dig_sel SHALL each pass through a two-flop synchronizer before any other use.
REQ-011 A stability counter SHALL increment while the synchronized {segm, dig_sel} equals its previous-cycle value, reset to 0 on any change, and saturate.
REQ-012 A sample SHALL be accepted exactly once per stable episode, on the cycle the counter reaches STABLE_CYCLES-1 (i.e. STABLE_CYCLES identical samples); it re-arms only after the input changes.
REQ-013 An accepted sample with dig_sel not exactly one zero bit SHALL be ignored: no capture, no error, frame state unchanged.
REQ-014 An accepted sample with segm=7'h7F (blank) SHALL be ignored likewise.
REQ-015 Decode table (segm hex -> nibble): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
REQ-016 Any other accepted pattern SHALL pulse digit_err on the cycle after acceptance, load err_digit with the selected index, and abort the frame (capture mask cleared, partial nibbles discarded).
REQ-017 FSM states: IDLE (mask=0) and COLLECT (mask nonzero); IDLE->COLLECT on first valid capture; COLLECT->IDLE on frame completion, error, or reset.
REQ-018 A valid capture SHALL write the nibble into a shadow register slot i and set mask bit i; recapture of an already-set slot overwrites it without error.
REQ-019 When the mask becomes 4'b1111, the shadow SHALL be copied to value and value_valid pulsed on the cycle after the completing acceptance; mask cleared the same cycle.
REQ-020 value SHALL hold between frames; value_valid and digit_err SHALL never be high in the same cycle.
REQ-021 Input-to-output latency: 2 sync cycles + STABLE_CYCLES + 1 cycle from a segm/dig_sel change to value_valid for the completing digit.

Reset
REQ-022 While reset is high at a clock edge: value=16'h0000, value_valid=0, digit_err=0, err_digit=0, mask=0, shadow=0, stability counter=0, synchronizers=all ones (blank, no digit), FSM=IDLE.
REQ-023 Reset mid-frame SHALL discard all captured nibbles; no value_valid results from pre-reset captures.

Verification
REQ-024 digit0..3 driven with 19,30,24,79 (one-hot dig_sel), each held 6 cycles -> exactly one value_valid, value=16'h1234.
REQ-025 Digit 0 with pattern 40 held only 3 cycles (STABLE_CYCLES=4), then other three digits valid -> no value_valid; frame stays in COLLECT with mask=4'b1110.
REQ-026 Digit 2 driven with 7E held 6 cycles after two valid digits -> digit_err pulse, err_digit=2, mask=0, no value_valid, value unchanged.
REQ-027 dig_sel=4'b1100 with segm=40 held 10 cycles -> no capture, no error; dig_sel=4'b1111 likewise.
REQ-028 Three valid digits, reset pulsed one cycle, then fourth digit -> no value_valid; value=16'h0000.
REQ-029 Digit 1 with pattern 12 held 100 cycles -> single acceptance; full frame later yields value nibble1=5 and one value_valid.
